// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and constants for the AXI-Stream packet arbiter
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry registered skid buffer; upstream ready never
// depends combinationally on downstream ready
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_s_tdata,
  input  logic             i_s_tvalid,
  output logic             o_s_tready,
  output logic [WIDTH-1:0] o_m_tdata,
  output logic             o_m_tvalid,
  input  logic             i_m_tready
);

  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_out_valid;
  logic             r_skid_valid;

  // The skid entry only fills when the output stage is stalled, so ready is its emptiness.
  assign o_s_tready = ~r_skid_valid;
  assign o_m_tdata  = r_out_data;
  assign o_m_tvalid = r_out_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (i_m_tready) begin
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end
    end else if (i_s_tvalid) begin
      if (!r_out_valid || i_m_tready) begin
        r_out_data  <= i_s_tdata;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_data  <= i_s_tdata;
        r_skid_valid <= 1'b1;
      end
    end else if (i_m_tready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - N-to-1 AXI-Stream packet arbiter (round-robin or fixed
// priority) with a skid-buffered master port
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  DATA_W    = 32,
  parameter int  PRIO_MODE = PRIO_RR,
  localparam int ID_W      = id_width(NUM_CH)
) (
  input  logic                     axis_aclk,
  input  logic                     axis_areset,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [ID_W-1:0]          m_axis_tid,
  output logic [NUM_CH-1:0]        grant
);

  localparam int              SKID_W   = DATA_W + ID_W + 1;
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_CH - 1);
  localparam logic [ID_W:0]   NCH_W    = (ID_W + 1)'(NUM_CH);

  arb_state_t        r_state;
  logic [NUM_CH-1:0] r_grant;
  logic [ID_W-1:0]   r_gidx;
  logic [ID_W-1:0]   r_ptr;

  logic              w_skid_ready;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic              w_last_xfer;
  logic              w_any_valid;
  logic [DATA_W-1:0] w_sel_data;
  logic [ID_W-1:0]   w_start;
  logic [ID_W-1:0]   w_off;
  logic [ID_W-1:0]   w_win_idx;
  logic [ID_W:0]     w_sum;
  logic [NUM_CH-1:0] w_rot;
  logic [NUM_CH-1:0] w_win_oh;
  logic [SKID_W-1:0] w_skid_out;

  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ID_W'(i);
    end
  endfunction

  always_comb begin
    w_start = '0;
    if (PRIO_MODE != PRIO_FIXED && r_ptr != LAST_IDX) w_start = r_ptr + 1'b1;
  end

  // Shifting the doubled request vector places the search start at bit 0, so the
  // lowest set bit is the winner's offset from the start.
  assign w_rot       = NUM_CH'({s_axis_tvalid, s_axis_tvalid} >> w_start);
  assign w_off       = lowest_set(w_rot);
  assign w_sum       = {1'b0, w_start} + {1'b0, w_off};
  assign w_win_idx   = (w_sum >= NCH_W) ? ID_W'(w_sum - NCH_W) : w_sum[ID_W-1:0];
  assign w_win_oh    = {{(NUM_CH - 1){1'b0}}, 1'b1} << w_win_idx;
  assign w_any_valid = |s_axis_tvalid;

  assign w_sel_data  = s_axis_tdata[r_gidx*DATA_W +: DATA_W];
  assign w_sel_valid = (r_state == LOCKED) && s_axis_tvalid[r_gidx];
  assign w_sel_last  = s_axis_tlast[r_gidx];
  assign w_last_xfer = w_sel_valid && w_skid_ready && w_sel_last;

  assign s_axis_tready = (r_state == LOCKED && w_skid_ready) ? r_grant : '0;
  assign grant         = r_grant;

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= LAST_IDX;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_state <= LOCKED;
            r_grant <= w_win_oh;
            r_gidx  <= w_win_idx;
            r_ptr   <= w_win_idx;
          end
        end
        LOCKED: begin
          // Re-arbitrate on the tlast beat itself so back-to-back packets see no bubble.
          if (w_last_xfer) begin
            if (w_any_valid) begin
              r_grant <= w_win_oh;
              r_gidx  <= w_win_idx;
              r_ptr   <= w_win_idx;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH(SKID_W)
  ) u_skid (
    .i_clk      (axis_aclk),
    .i_rst      (axis_areset),
    .i_s_tdata  ({r_gidx, w_sel_last, w_sel_data}),
    .i_s_tvalid (w_sel_valid),
    .o_s_tready (w_skid_ready),
    .o_m_tdata  (w_skid_out),
    .o_m_tvalid (m_axis_tvalid),
    .i_m_tready (m_axis_tready)
  );

  assign m_axis_tid   = w_skid_out[SKID_W-1 -: ID_W];
  assign m_axis_tlast = w_skid_out[DATA_W];
  assign m_axis_tdata = w_skid_out[DATA_W-1:0];

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - self-checking bench for axis_rr_arbiter in both arbitration modes
module tb_axis_rr_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int IW  = 2;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic [NCH*DW-1:0] s_tdata  = '0;
  logic [NCH-1:0]    s_tvalid = '0;
  logic [NCH-1:0]    s_tlast  = '0;
  logic              m_tready = 1'b1;
  logic              sel_fp   = 1'b0;
  bit                rand_ready = 1'b0;
  logic [15:0]       lfsr     = 16'hACE1;

  logic [NCH-1:0] rr_s_tready, fp_s_tready, rr_grant, fp_grant;
  logic [DW-1:0]  rr_m_tdata, fp_m_tdata;
  logic           rr_m_tvalid, fp_m_tvalid, rr_m_tlast, fp_m_tlast;
  logic [IW-1:0]  rr_m_tid, fp_m_tid;

  logic [NCH-1:0] w_s_tready, w_grant;
  logic [DW-1:0]  w_m_tdata;
  logic           w_m_tvalid, w_m_tlast;
  logic [IW-1:0]  w_m_tid;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .PRIO_MODE(0)) u_rr (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(rr_s_tready),
    .m_axis_tdata(rr_m_tdata), .m_axis_tvalid(rr_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(rr_m_tlast), .m_axis_tid(rr_m_tid), .grant(rr_grant)
  );

  axis_rr_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .PRIO_MODE(1)) u_fp (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(fp_s_tready),
    .m_axis_tdata(fp_m_tdata), .m_axis_tvalid(fp_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(fp_m_tlast), .m_axis_tid(fp_m_tid), .grant(fp_grant)
  );

  assign w_s_tready = sel_fp ? fp_s_tready : rr_s_tready;
  assign w_grant    = sel_fp ? fp_grant    : rr_grant;
  assign w_m_tdata  = sel_fp ? fp_m_tdata  : rr_m_tdata;
  assign w_m_tvalid = sel_fp ? fp_m_tvalid : rr_m_tvalid;
  assign w_m_tlast  = sel_fp ? fp_m_tlast  : rr_m_tlast;
  assign w_m_tid    = sel_fp ? fp_m_tid    : rr_m_tid;

  // Per-channel pending beats {last,data}, and beats accepted but not yet seen at the output.
  logic [DW:0]    txq  [NCH][$];
  logic [DW:0]    expq [NCH][$];
  logic [IW+DW:0] out_log[$];
  int             out_cyc[$];
  int             pkt_order[$];
  int             in_cnt [NCH];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  bit             in_pkt = 1'b0;
  int             cur_tid = 0;
  bit             prev_stall = 1'b0;
  logic [IW+DW:0] prev_beat = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW+DW:0] mk(input int tid, input bit last, input logic [DW-1:0] d);
    return {IW'(tid), last, d};
  endfunction

  task automatic push_beats(input int c, input logic [DW-1:0] base, input int n);
    for (int b = 0; b < n; b++) txq[c].push_back({b == n - 1, base + DW'(b)});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : driver
    logic [DW:0] b;
    forever begin
      @(posedge clk);
      #2;
      for (int c = 0; c < NCH; c++) begin
        if (txq[c].size() > 0) begin
          b = txq[c][0];
          s_tvalid[c]            = 1'b1;
          s_tlast[c]             = b[DW];
          s_tdata[c*DW +: DW]    = b[DW-1:0];
        end else begin
          s_tvalid[c]            = 1'b0;
          s_tlast[c]             = 1'b0;
          s_tdata[c*DW +: DW]    = '0;
        end
      end
      if (rand_ready) begin
        lfsr     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        m_tready = lfsr[0];
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic [DW:0]     b;
    logic [DW:0]     e;
    logic [IW+DW:0]  beat;
    logic [NCH-1:0]  g;
    int              tid;
    forever begin
      @(negedge clk);
      beat = {w_m_tid, w_m_tlast, w_m_tdata};
      if (rst) begin
        for (int c = 0; c < NCH; c++) expq[c].delete();
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (s_tvalid[c] && w_s_tready[c] && txq[c].size() > 0) begin
            b = txq[c].pop_front();
            expq[c].push_back(b);
            in_cnt[c]++;
          end
        end
        g = w_grant;
        chk((g & (g - 1'b1)) == '0, "grant_onehot", 64'(g), 64'(g & (~g + 1'b1)));
        chk((w_s_tready & ~g) == '0, "tready_outside_grant", 64'(w_s_tready), 64'(w_s_tready & g));
        if (prev_stall)
          chk(w_m_tvalid && beat == prev_beat, "hold_while_stalled",
              64'({w_m_tvalid, beat}), 64'({1'b1, prev_beat}));
        if (w_m_tvalid && m_tready) begin
          tid = int'(w_m_tid);
          if (expq[tid].size() == 0) begin
            chk(1'b0, "unexpected_beat", 64'(beat), 64'(0));
          end else begin
            e = expq[tid].pop_front();
            chk({w_m_tlast, w_m_tdata} == e, "beat_vs_model", 64'({w_m_tlast, w_m_tdata}), 64'(e));
          end
          if (!in_pkt) begin
            pkt_order.push_back(tid);
            cur_tid = tid;
            in_pkt  = 1'b1;
          end else begin
            chk(tid == cur_tid, "no_interleave", 64'(tid), 64'(cur_tid));
          end
          if (w_m_tlast) in_pkt = 1'b0;
          out_log.push_back(beat);
          out_cyc.push_back(cyc);
        end
        prev_stall = w_m_tvalid && !m_tready;
        prev_beat  = beat;
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    logic [63:0] v;
    v = 64'({w_m_tvalid, w_m_tlast, w_m_tdata, w_m_tid, w_s_tready, w_grant});
    chk(v == 64'(0), name, v, 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      txq[c].delete();
      in_cnt[c] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    @(posedge clk);
    #1;
    out_log.delete();
    out_cyc.delete();
    pkt_order.delete();
    rst = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(out_log.size() == n, name, 64'(out_log.size()), 64'(n));
  endtask

  initial begin : tests
    int t0;
    int k;
    @(posedge clk);
    #1;

    // Single 10-beat packet on ch0 with master always ready.
    do_reset();
    t0 = cyc;
    push_beats(0, 32'd1, 10);
    wait_out(10, 100, "t1_beat_count");
    for (int i = 0; i < 10 && i < out_log.size(); i++)
      chk(out_log[i] == mk(0, i == 9, DW'(i + 1)), "t1_beat", 64'(out_log[i]), 64'(mk(0, i == 9, DW'(i + 1))));
    if (out_cyc.size() > 0)
      chk(out_cyc[0] - t0 == 2, "t1_first_latency", 64'(out_cyc[0] - t0), 64'(2));

    // ch0 and ch2 start together: ch0 first, then ch2 back to back.
    do_reset();
    push_beats(0, 32'hA0, 3);
    push_beats(2, 32'hC0, 3);
    wait_out(6, 100, "t2_beat_count");
    for (int i = 0; i < 6 && i < out_log.size(); i++) begin
      if (i < 3)
        chk(out_log[i] == mk(0, i == 2, 32'hA0 + DW'(i)), "t2_beat", 64'(out_log[i]), 64'(mk(0, i == 2, 32'hA0 + DW'(i))));
      else
        chk(out_log[i] == mk(2, i == 5, 32'hC0 + DW'(i - 3)), "t2_beat", 64'(out_log[i]), 64'(mk(2, i == 5, 32'hC0 + DW'(i - 3))));
    end
    if (out_cyc.size() == 6)
      chk(out_cyc[5] - out_cyc[0] == 5, "t2_no_bubble", 64'(out_cyc[5] - out_cyc[0]), 64'(5));

    // All four channels busy, round-robin: grant order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < 2; p++) push_beats(c, DW'(c * 256 + p * 16), 2);
    wait_out(16, 200, "t3_beat_count");
    chk(pkt_order.size() == 8, "t3_pkt_count", 64'(pkt_order.size()), 64'(8));
    for (int i = 0; i < 8 && i < pkt_order.size(); i++)
      chk(pkt_order[i] == i % 4, "t3_rr_order", 64'(pkt_order[i]), 64'(i % 4));

    // Same load in fixed priority: ch0 keeps winning while it has packets.
    sel_fp = 1'b1;
    do_reset();
    for (int p = 0; p < 8; p++) push_beats(0, DW'(p * 16), 2);
    for (int c = 1; c < NCH; c++)
      for (int p = 0; p < 2; p++) push_beats(c, DW'(c * 256 + p * 16), 2);
    wait_out(16, 200, "t4_beat_count");
    for (int i = 0; i < 8 && i < pkt_order.size(); i++)
      chk(pkt_order[i] == 0, "t4_fixed_order", 64'(pkt_order[i]), 64'(0));

    // Random master backpressure on two channels, two 10-beat packets each.
    sel_fp = 1'b0;
    do_reset();
    rand_ready = 1'b1;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < 2; p++) push_beats(c, DW'(c * 4096 + p * 256), 10);
    wait_out(40, 1000, "t5_beat_count");
    rand_ready = 1'b0;
    chk(expq[0].size() + expq[1].size() == 0, "t5_no_loss", 64'(expq[0].size() + expq[1].size()), 64'(0));
    chk(pkt_order.size() == 4, "t5_pkt_count", 64'(pkt_order.size()), 64'(4));
    for (int i = 0; i < 4 && i < pkt_order.size(); i++)
      chk(pkt_order[i] == i % 2, "t5_rr_order", 64'(pkt_order[i]), 64'(i % 2));

    // Reset after beat 4 of 10 on ch1, then a fresh arbitration from ch0 and ch3.
    do_reset();
    push_beats(1, 32'h100, 10);
    k = 0;
    while (in_cnt[1] < 4 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(in_cnt[1] == 4, "t6_beats_before_reset", 64'(in_cnt[1]), 64'(4));
    rst = 1'b1;
    txq[1].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("t6_outputs_after_reset");
    chk(out_log.size() == 3, "t6_beats_out_before_reset", 64'(out_log.size()), 64'(3));
    @(posedge clk);
    #1;
    out_log.delete();
    out_cyc.delete();
    pkt_order.delete();
    push_beats(0, 32'hD0, 3);
    push_beats(3, 32'hE0, 2);
    wait_out(5, 100, "t6_beat_count");
    chk(pkt_order.size() == 2 && pkt_order[0] == 0 && pkt_order[1] == 3, "t6_order_after_reset",
        64'(pkt_order.size() > 0 ? pkt_order[0] : -1), 64'(0));
    if (out_log.size() > 0)
      chk(out_log[0] == mk(0, 1'b0, 32'hD0), "t6_first_beat", 64'(out_log[0]), 64'(mk(0, 1'b0, 32'hD0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of slave channels (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the tdata width in bits.
REQ-003 The block SHALL have parameter PRIO_MODE, default 0, where 0 selects round-robin and 1 selects fixed priority (channel 0 highest).
REQ-004 The block SHALL have localparam ID_W = max(1, clog2(NUM_CH)).
REQ-005 The block SHALL have port axis_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port axis_areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port s_axis_tdata, input, NUM_CH*DATA_W bits: packed slave data, channel i at [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port s_axis_tvalid, input, NUM_CH bits: per-channel valid.
REQ-009 The block SHALL have port s_axis_tlast, input, NUM_CH bits: per-channel end of packet.
REQ-010 The block SHALL have port s_axis_tready, output, NUM_CH bits: per-channel ready.
REQ-011 The block SHALL have port m_axis_tdata, output, DATA_W bits: master data.
REQ-012 The block SHALL have port m_axis_tvalid, output, 1 bit: master valid.
REQ-013 The block SHALL have port m_axis_tready, input, 1 bit: master ready.
REQ-014 The block SHALL have port m_axis_tlast, output, 1 bit: master end of packet.
REQ-015 The block SHALL have port m_axis_tid, output, ID_W bits: source channel index of the current beat.
REQ-016 The block SHALL have port grant, output, NUM_CH bits: one-hot current grant, or zero when idle.

Function
REQ-017 A transfer SHALL occur on any channel exactly when both tvalid and tready are 1 at a rising edge.
REQ-018 The arbiter FSM SHALL have two states: IDLE, with no grant, and LOCKED, with one channel granted.
REQ-019 In IDLE with any s_axis_tvalid set, the FSM SHALL register a winner into grant and enter LOCKED on the next edge; s_axis_tready SHALL stay 0 while in IDLE.
REQ-020 In LOCKED, s_axis_tready[g] SHALL equal the skid-buffer input ready, and all other tready bits SHALL be 0.
REQ-021 Once granted, a channel SHALL hold the grant until its tlast beat transfers into the block; there is no interleaving within a packet.
REQ-022 When the tlast beat transfers and other tvalid bits (or the same bit) are set, the FSM SHALL re-arbitrate in the same cycle and remain in LOCKED, with no idle bubble; otherwise it SHALL return to IDLE.
REQ-023 In round-robin mode, the search SHALL start at (last granted + 1) mod NUM_CH and the lowest index at or after that start wins; the pointer updates only on a grant.
REQ-024 In fixed-priority mode, the lowest-index valid channel SHALL win.
REQ-025 The output path SHALL pass through a 2-entry skid buffer: full throughput, one cycle of latency, and m_axis_tready never combinationally reaching s_axis_tready.
REQ-026 m_axis_tid SHALL carry the granted index, registered alongside tdata and tlast.
REQ-027 A deasserted tvalid mid-packet SHALL hold the grant; the block waits without timeout.
REQ-028 m_axis_tvalid, once asserted, SHALL NOT drop, and its data SHALL NOT change until it is accepted.
REQ-029 Minimum latency SHALL be 2 cycles from s tvalid rising in IDLE to m_axis_tvalid: 1 cycle to grant, 1 cycle through the skid buffer.

Reset
REQ-030 While axis_areset=1, the block SHALL drive m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tid=0, s_axis_tready=0 and grant=0; the FSM SHALL be in IDLE, the RR pointer at NUM_CH-1 (so channel 0 is first), and the skid buffer empty.
REQ-031 A reset asserted mid-packet SHALL discard all buffered beats, with no partial packet completion after reset.

Structure
REQ-032 Package axis_arb_pkg SHALL hold the arb_state_t enum (IDLE, LOCKED) and the PRIO_RR=0 / PRIO_FIXED=1 constants.
REQ-033 The skid buffer SHALL be the sub-module axis_skid_buffer, parametrised by width DATA_W+ID_W+1.
REQ-034 Round-robin selection SHALL use a doubled-vector rotate-and-priority scheme, with no loops over a variable bound.

Verification
REQ-035 The bench SHALL run NUM_CH=4 with ch0 sending 10 beats (1..10, tlast on 10) and tready=1, and SHALL see m data 1..10 with tid=0, first beat 2 cycles after tvalid, and tlast only on 10.
REQ-036 The bench SHALL have ch0 and ch2 each start 3-beat packets in the same cycle in RR mode after reset, and SHALL see the ch0 packet complete, then ch2, with no beat interleaving and no bubble between packets.
REQ-037 The bench SHALL run all 4 channels continuously valid in RR mode over 8 packets, and SHALL see grant order 0,1,2,3,0,1,2,3.
REQ-038 The bench SHALL repeat the 4-channel scenario in PRIO_MODE=1, and SHALL see ch0 win every arbitration while it remains valid.
REQ-039 The bench SHALL apply pseudorandom m_axis_tready (LFSR, about 50%) to 2x10-beat packets on 2 channels, and SHALL see the output written to file match the input sequence per tid, with no loss or duplication.
REQ-040 The bench SHALL assert reset for 1 cycle after beat 4 of 10 on ch1, and SHALL see all outputs 0 on the following cycle and a fresh packet from ch0 arbitrated normally afterwards.
